// File: rtl/vram_hdma.sv
`default_nettype none
// ==========================================================================
// vram_hdma : CGB VRAM DMA engine, GDMA and HBlank-paced 16-byte blocks
// Revision  : 1.0
// ==========================================================================
module vram_hdma #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  reg_sel,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  hdma5_rdata,
  input  logic        hblank,
  input  logic        lcd_on,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [12:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata
);

  localparam logic [15:0] SRC_STEP  = 16'(BLOCK_BYTES);
  localparam logic [12:0] DST_STEP  = 13'(BLOCK_BYTES);
  localparam logic [3:0]  LAST_BYTE = 4'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GDMA_RUN  = 3'd1,
    HDMA_WAIT = 3'd2,
    HDMA_BLK  = 3'd3,
    HDMA_GAP  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  src_hi;
  logic [3:0]  src_lo;
  logic [4:0]  dst_hi;
  logic [3:0]  dst_lo;
  logic [15:0] src;
  logic [12:0] dst;
  logic [6:0]  len;
  logic [4:0]  cnt;        // bit 4 marks the write-only tail cycle of a block
  logic        last;
  logic        term_pend;
  logic        hblank_q;
  logic        wr_valid;
  logic [12:0] wr_addr;
  logic [7:0]  status;
  logic        hdma5_wr;
  logic        term_wr;
  logic        hblank_rise;

  assign hdma5_wr    = reg_wr && (reg_sel == 3'd5);
  assign term_wr     = hdma5_wr && !reg_wdata[7];
  assign hblank_rise = hblank && !hblank_q;

  assign mem_addr    = src + {12'd0, cnt[3:0]};
  assign vram_addr   = wr_addr;
  assign vram_we     = wr_valid;
  assign vram_wdata  = mem_rdata;
  assign hdma5_rdata = (state == IDLE) ? status : {1'b0, len};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cpu_stall = 1'b0;
    mem_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (hdma5_wr) state_nx = reg_wdata[7] ? HDMA_WAIT : GDMA_RUN;
      end
      GDMA_RUN: begin
        cpu_stall = 1'b1;
        mem_rd    = !cnt[4];
        if (cnt[4]) state_nx = IDLE;
      end
      HDMA_WAIT: begin
        // A terminating write beats a coincident HBlank edge.
        if (term_wr)                      state_nx = IDLE;
        else if (hblank_rise || !lcd_on)  state_nx = HDMA_BLK;
      end
      HDMA_BLK: begin
        cpu_stall = 1'b1;
        mem_rd    = !cnt[4];
        if (cnt[4]) state_nx = (last || term_pend || term_wr) ? IDLE : HDMA_GAP;
      end
      HDMA_GAP: begin
        if (term_wr)                state_nx = IDLE;
        else if (!lcd_on || !hblank) state_nx = HDMA_WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_hi    <= 8'd0;
      src_lo    <= 4'd0;
      dst_hi    <= 5'd0;
      dst_lo    <= 4'd0;
      src       <= 16'd0;
      dst       <= 13'd0;
      len       <= 7'd0;
      cnt       <= 5'd0;
      last      <= 1'b0;
      term_pend <= 1'b0;
      hblank_q  <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 13'd0;
      status    <= 8'hFF;
    end else begin
      hblank_q <= hblank;
      wr_valid <= mem_rd;
      wr_addr  <= dst + {9'd0, cnt[3:0]};

      // Register writes always land here; working counters only reload on start.
      if (reg_wr) begin
        case (reg_sel)
          3'd1:    src_hi <= reg_wdata;
          3'd2:    src_lo <= reg_wdata[7:4];
          3'd3:    dst_hi <= reg_wdata[4:0];
          3'd4:    dst_lo <= reg_wdata[7:4];
          default: ;
        endcase
      end

      if (state == IDLE && hdma5_wr) begin
        src       <= {src_hi, src_lo, 4'h0};
        dst       <= {dst_hi, dst_lo, 4'h0};
        len       <= reg_wdata[6:0];
        cnt       <= 5'd0;
        last      <= 1'b0;
        term_pend <= 1'b0;
      end

      if (mem_rd) begin
        if (cnt[3:0] == LAST_BYTE) begin
          src  <= src + SRC_STEP;
          dst  <= dst + DST_STEP;
          len  <= len - 7'd1;
          last <= (len == 7'd0);
          // GDMA overlaps the next block's first read with this block's last write.
          cnt  <= (state == GDMA_RUN && len != 7'd0) ? 5'd0 : 5'd16;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end else if (cnt[4]) begin
        cnt <= 5'd0;
      end

      if (state == HDMA_BLK && term_wr) term_pend <= 1'b1;

      if (state != IDLE && state_nx == IDLE)
        status <= (state == GDMA_RUN || (state == HDMA_BLK && last)) ? 8'hFF : {1'b1, len};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_hdma.sv
`default_nettype none
// ==========================================================================
// tb_vram_hdma : scoreboard bench for vram_hdma with a block-level model
// Revision     : 1.0
// ==========================================================================
module tb_vram_hdma;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  reg_sel;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  hdma5_rdata;
  logic        hblank;
  logic        lcd_on;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;

  vram_hdma #(.BLOCK_BYTES(16)) dut (
    .clock(clock), .reset(reset), .reg_sel(reg_sel), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .hdma5_rdata(hdma5_rdata), .hblank(hblank),
    .lcd_on(lcd_on), .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem [0:65535];
  logic [20:0] exp_q [$];
  logic [15:0] m_src;
  logic [12:0] m_dst;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  int          wr_seen = 0;

  // Bus slave: read data is valid the cycle after the strobe.
  always @(posedge clock) mem_rdata <= mem_rd ? mem[mem_addr] : 8'h00;

  // Monitor: every VRAM write is popped from the scoreboard.
  always @(negedge clock) begin
    logic [20:0] e;
    if (cpu_stall) stall_cnt++;
    if (vram_we) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vram_write_unexpected: got addr=%h data=%h, required no write", vram_addr, vram_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({vram_addr, vram_wdata} !== e) begin
          errors++;
          $display("FAIL vram_write: got addr=%h data=%h, required addr=%h data=%h",
                   vram_addr, vram_wdata, e[20:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, required completion", name);
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [7:0] d);
    @(posedge clock); #1;
    reg_sel = sel; reg_wdata = d; reg_wr = 1'b1;
    @(posedge clock); #1;
    reg_wr = 1'b0; reg_sel = 3'd0;
  endtask

  task automatic prog(input logic [7:0] h1, input logic [7:0] h2, input logic [7:0] h3, input logic [7:0] h4);
    wr_reg(3'd1, h1); wr_reg(3'd2, h2); wr_reg(3'd3, h3); wr_reg(3'd4, h4);
    m_src = {h1, h2[7:4], 4'h0};
    m_dst = {h3[4:0], h4[7:4], 4'h0};
  endtask

  task automatic push_block();
    logic [15:0] a;
    logic [12:0] v;
    for (int k = 0; k < 16; k++) begin
      a = m_src + 16'(k);
      v = m_dst + 13'(k);
      exp_q.push_back({v, mem[a]});
    end
    m_src = m_src + 16'd16;
    m_dst = m_dst + 13'd16;
  endtask

  task automatic pulse_hblank();
    @(posedge clock); #1 hblank = 1'b1;
    repeat (2) @(posedge clock);
    #1 hblank = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clock); n++; end
    while (!(hdma5_rdata == 8'hFF && !cpu_stall) && n < 3000);
    if (n >= 3000) timeout(name);
  endtask

  task automatic wait_block(input string name);
    int n = 0;
    do begin @(negedge clock); n++; end
    while (!(stall_cnt > 0 && !cpu_stall) && n < 100);
    if (n >= 100) timeout(name);
  endtask

  task automatic quiet_hblank(input string name);
    stall_cnt = 0;
    pulse_hblank();
    repeat (30) @(posedge clock);
    @(negedge clock);
    chk(name, stall_cnt, 0);
  endtask

  task automatic run_gdma(input string name, input int n);
    for (int b = 0; b < n; b++) push_block();
    stall_cnt = 0;
    wr_reg(3'd5, 8'(n - 1));
    wait_idle(name);
    chk({name, "_stall"}, stall_cnt, 16 * n + 1);
    chk({name, "_hdma5"}, hdma5_rdata, 8'hFF);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; reg_sel = 3'd0; reg_wr = 1'b0; reg_wdata = 8'd0;
    hblank = 1'b0; lcd_on = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_hdma5", hdma5_rdata, 8'hFF);
    chk("reset_stall", cpu_stall, 1'b0);
    chk("reset_we", vram_we, 1'b0);
    chk("reset_rd", mem_rd, 1'b0);
    @(posedge clock); #1 reset = 1'b0;

    // Directed GDMA of two blocks.
    prog(8'h12, 8'h34, 8'h91, 8'h20);
    push_block(); push_block();
    stall_cnt = 0;
    wr_reg(3'd5, 8'h01);
    @(negedge clock);
    chk("gdma_first_addr", mem_addr, 16'h1230);
    chk("gdma_first_rd", mem_rd, 1'b1);
    wait_idle("gdma2_done");
    chk("gdma2_stall", stall_cnt, 33);
    chk("gdma2_hdma5", hdma5_rdata, 8'hFF);
    chk("gdma2_drain", exp_q.size(), 0);

    // Randomized GDMA transfers.
    for (int t = 0; t < 4; t++) begin
      prog(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_gdma("gdma_rand", int'($urandom_range(1, 3)));
    end

    // Address wrap on both sides.
    prog(8'hFF, 8'hF0, 8'h1F, 8'hF0);
    run_gdma("gdma_wrap", 2);

    // HBlank mode, three blocks, with a shadow write mid-transfer.
    prog(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    wr_reg(3'd5, 8'h82);
    @(negedge clock);
    chk("hdma_pre", hdma5_rdata, 8'h02);
    for (int b = 0; b < 3; b++) begin
      repeat (3) @(posedge clock);
      if (b == 1) wr_reg(3'd1, 8'hAB);
      push_block();
      stall_cnt = 0;
      pulse_hblank();
      wait_block("hdma_blk");
      chk("hdma_blk_stall", stall_cnt, 17);
      chk("hdma_blk_hdma5", hdma5_rdata, (b < 2) ? 32'(1 - b) : 32'hFF);
      chk("hdma_blk_drain", exp_q.size(), 0);
    end

    // Termination while waiting for HBlank.
    prog(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    wr_reg(3'd5, 8'h85);
    @(negedge clock);
    chk("term_pre", hdma5_rdata, 8'h05);
    push_block();
    stall_cnt = 0;
    pulse_hblank();
    wait_block("term_blk");
    chk("term_blk_hdma5", hdma5_rdata, 8'h04);
    repeat (3) @(posedge clock);
    wr_reg(3'd5, 8'h00);
    @(negedge clock);
    chk("term_hdma5", hdma5_rdata, 8'h84);
    quiet_hblank("term_quiet");

    // Termination requested mid-block: block completes first.
    prog(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    wr_reg(3'd5, 8'h83);
    push_block();
    stall_cnt = 0;
    wr_seen = 0;
    pulse_hblank();
    n = 0;
    while (wr_seen < 5 && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) timeout("midterm_byte5");
    wr_reg(3'd5, 8'h00);
    wait_block("midterm_blk");
    chk("midterm_stall", stall_cnt, 17);
    chk("midterm_drain", exp_q.size(), 0);
    chk("midterm_hdma5", hdma5_rdata, 8'h82);
    quiet_hblank("midterm_quiet");

    // LCD off: HDMA blocks run back-to-back.
    lcd_on = 1'b0;
    prog(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    n = int'($urandom_range(1, 3));
    for (int b = 0; b < n; b++) push_block();
    stall_cnt = 0;
    wr_reg(3'd5, 8'h80 | 8'(n - 1));
    wait_idle("lcdoff_done");
    chk("lcdoff_stall", stall_cnt, 17 * n);
    chk("lcdoff_drain", exp_q.size(), 0);
    lcd_on = 1'b1;

    // Asynchronous reset in the middle of a GDMA block.
    prog(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    push_block();
    wr_seen = 0;
    wr_reg(3'd5, 8'h00);
    n = 0;
    while (wr_seen < 7 && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) timeout("rst_byte7");
    @(posedge clock); #2 reset = 1'b1;
    #1;
    chk("rst_async_we", vram_we, 1'b0);
    chk("rst_async_stall", cpu_stall, 1'b0);
    chk("rst_async_rd", mem_rd, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_hdma5_after", hdma5_rdata, 8'hFF);
    quiet_hblank("rst_quiet");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
